// File: rtl/ocm_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package : ocm_sched_pkg
// Brief   : Shared state encoding and parameter defaults for the OCM write
//           scheduler and its round-robin arbiter.
// Rev     : 1.0 - initial release
// ============================================================================
package ocm_sched_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int ADDR_W_DEF      = 17;
  localparam int CLEAR_DEPTH_DEF = 4001;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

endpackage : ocm_sched_pkg
`default_nettype wire

// File: rtl/ocm_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : ocm_rr_arb2
// Brief  : Two-requester round-robin grant. prio_b_i selects who wins when
//          both requesters are valid; grant_o is one-hot (bit0 = A, bit1 = B).
// Rev    : 1.0 - initial release
// ============================================================================
module ocm_rr_arb2
  import ocm_sched_pkg::*;
(
  input  logic       valid_a_i,
  input  logic       valid_b_i,
  input  logic       prio_b_i,
  output logic [1:0] grant_o
);

  // A wins when alone or when it holds priority; otherwise B wins if valid.
  always_comb begin
    grant_o = 2'b00;
    if (valid_a_i && (!valid_b_i || !prio_b_i)) begin
      grant_o = 2'b01;
    end else if (valid_b_i) begin
      grant_o = 2'b10;
    end
  end

endmodule : ocm_rr_arb2
`default_nettype wire

// File: rtl/ocm_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module : ocm_write_scheduler
// Brief  : Drives a single OCM write port. After reset (or on request) it
//          zeroes words 0..CLEAR_DEPTH-1, then arbitrates two write
//          requesters round-robin with a registered OCM interface.
// Rev    : 1.0 - initial release
// ============================================================================
module ocm_write_scheduler
  import ocm_sched_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int CLEAR_DEPTH = CLEAR_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_start,
  input  logic              reqA_valid,
  input  logic [ADDR_W-1:0] reqA_addr,
  input  logic [DATA_W-1:0] reqA_data,
  input  logic              reqB_valid,
  input  logic [ADDR_W-1:0] reqB_addr,
  input  logic [DATA_W-1:0] reqB_data,
  output logic              reqA_ready,
  output logic              reqB_ready,
  output logic [DATA_W-1:0] ocm_writedata,
  output logic [ADDR_W-1:0] ocm_addr,
  output logic              ocm_chip,
  output logic              ocm_clk_enab,
  output logic              ocm_write,
  output logic              clear_busy,
  output logic [15:0]       write_count
);

  // Address of the final word zeroed by a clear pass.
  localparam logic [ADDR_W-1:0] C_LAST_CLR = ADDR_W'(CLEAR_DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              prio_b_q, prio_b_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic              cen_q, cen_d;
  logic              chip_q, chip_d;

  logic [1:0]        arb_grant;
  logic              grant_en;
  logic              xfer_a;
  logic              xfer_b;

  ocm_rr_arb2 u_arb (
    .valid_a_i (reqA_valid),
    .valid_b_i (reqB_valid),
    .prio_b_i  (prio_b_q),
    .grant_o   (arb_grant)
  );

  // Grants are only offered while running and not in a clear-request cycle.
  always_comb begin
    grant_en   = (state_q == S_RUN) && !clear_start;
    reqA_ready = grant_en && arb_grant[0];
    reqB_ready = grant_en && arb_grant[1];
    xfer_a     = reqA_ready && reqA_valid;
    xfer_b     = reqB_ready && reqB_valid;
  end

  // Next-state logic for the clear/run sequencer and the OCM output stage.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    prio_b_d   = prio_b_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    write_d    = 1'b0;
    cen_d      = 1'b0;
    chip_d     = 1'b1;

    if (state_q == S_CLEAR) begin
      write_d = 1'b1;
      cen_d   = 1'b1;
      addr_d  = clr_addr_q;
      wdata_d = '0;
      if (clr_addr_q == C_LAST_CLR) begin
        state_d    = S_RUN;
        clr_addr_d = '0;
      end else begin
        clr_addr_d = clr_addr_q + 1'b1;
      end
    end else if (clear_start) begin
      state_d    = S_CLEAR;
      clr_addr_d = '0;
      cnt_d      = '0;
    end else if (xfer_a || xfer_b) begin
      write_d  = 1'b1;
      cen_d    = 1'b1;
      addr_d   = xfer_a ? reqA_addr : reqB_addr;
      wdata_d  = xfer_a ? reqA_data : reqB_data;
      // After A is served B takes priority, and vice versa.
      prio_b_d = xfer_a;
      if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // State and output registers; asynchronous reset restarts the clear pass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      prio_b_q   <= 1'b0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      cen_q      <= 1'b0;
      chip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      prio_b_q   <= prio_b_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      cen_q      <= cen_d;
      chip_q     <= chip_d;
    end
  end

  // Drive registered outputs.
  always_comb begin
    ocm_writedata = wdata_q;
    ocm_addr      = addr_q;
    ocm_write     = write_q;
    ocm_clk_enab  = cen_q;
    ocm_chip      = chip_q;
    clear_busy    = (state_q == S_CLEAR);
    write_count   = cnt_q;
  end

endmodule : ocm_write_scheduler
`default_nettype wire

// File: tb/tb_ocm_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_ocm_write_scheduler
// Brief  : Self-checking bench with a behavioural model of the scheduler,
//          directed literal scenarios and a randomized phase.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ocm_write_scheduler;

  localparam int DW    = 8;
  localparam int AW    = 17;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear_start = 1'b0;
  logic          reqA_valid = 1'b0, reqB_valid = 1'b0;
  logic [AW-1:0] reqA_addr = '0, reqB_addr = '0;
  logic [DW-1:0] reqA_data = '0, reqB_data = '0;
  logic          reqA_ready, reqB_ready;
  logic [DW-1:0] ocm_writedata;
  logic [AW-1:0] ocm_addr;
  logic          ocm_chip, ocm_clk_enab, ocm_write, clear_busy;
  logic [15:0]   write_count;

  int n_cmp = 0;
  int n_bad = 0;

  ocm_write_scheduler #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .clear_start(clear_start),
    .reqA_valid(reqA_valid), .reqA_addr(reqA_addr), .reqA_data(reqA_data),
    .reqB_valid(reqB_valid), .reqB_addr(reqB_addr), .reqB_data(reqB_data),
    .reqA_ready(reqA_ready), .reqB_ready(reqB_ready),
    .ocm_writedata(ocm_writedata), .ocm_addr(ocm_addr), .ocm_chip(ocm_chip),
    .ocm_clk_enab(ocm_clk_enab), .ocm_write(ocm_write),
    .clear_busy(clear_busy), .write_count(write_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit            m_clearing;
  int            m_caddr;
  bit            m_last_b;     // most recently granted requester was B
  int            m_cnt;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic          e_wr, e_cen, e_chip;

  function automatic void model_reset();
    m_clearing = 1; m_caddr = 0; m_last_b = 1; m_cnt = 0;
    e_addr = '0; e_data = '0; e_wr = 0; e_cen = 0; e_chip = 0;
  endfunction

  // Which requester the rules say wins right now (bit0 A, bit1 B).
  function automatic logic [1:0] model_grant();
    if (m_clearing || clear_start) return 2'b00;
    if (reqA_valid && reqB_valid) return m_last_b ? 2'b01 : 2'b10;
    if (reqA_valid) return 2'b01;
    if (reqB_valid) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    logic [1:0] g;
    if (!reset_n) begin
      model_reset();
    end else begin
      g = model_grant();
      if (m_clearing) begin
        e_addr = AW'(m_caddr); e_data = '0; e_wr = 1; e_cen = 1; e_chip = 1;
        if (m_caddr == DEPTH - 1) begin m_clearing = 0; m_caddr = 0; end
        else m_caddr = m_caddr + 1;
      end else begin
        e_wr = 0; e_cen = 0; e_chip = 1;
        if (clear_start) begin
          m_clearing = 1; m_caddr = 0; m_cnt = 0;
        end else if (g != 2'b00) begin
          e_wr = 1; e_cen = 1;
          if (g[0]) begin e_addr = reqA_addr; e_data = reqA_data; m_last_b = 0; end
          else      begin e_addr = reqB_addr; e_data = reqB_data; m_last_b = 1; end
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, then compare all outputs.
  task automatic step(input logic va, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic vb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                      input logic cs);
    logic [1:0] g;
    @(negedge clk);
    reqA_valid = va; reqA_addr = aa; reqA_data = da;
    reqB_valid = vb; reqB_addr = ab; reqB_data = db;
    clear_start = cs;
    #1;
    g = model_grant();
    chk("reqA_ready",    32'(reqA_ready),    32'(g[0]));
    chk("reqB_ready",    32'(reqB_ready),    32'(g[1]));
    chk("ocm_addr",      32'(ocm_addr),      32'(e_addr));
    chk("ocm_writedata", 32'(ocm_writedata), 32'(e_data));
    chk("ocm_write",     32'(ocm_write),     32'(e_wr));
    chk("ocm_clk_enab",  32'(ocm_clk_enab),  32'(e_cen));
    chk("ocm_chip",      32'(ocm_chip),      32'(e_chip));
    chk("clear_busy",    32'(clear_busy),    32'(m_clearing));
    chk("write_count",   32'(write_count),   32'(m_cnt));
  endtask

  task automatic idle();
    step(0, '0, '0, 0, '0, '0, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  32'(ocm_addr), 0);
    chk({tag, "_data"},  32'(ocm_writedata), 0);
    chk({tag, "_write"}, 32'(ocm_write), 0);
    chk({tag, "_cen"},   32'(ocm_clk_enab), 0);
    chk({tag, "_chip"},  32'(ocm_chip), 0);
    chk({tag, "_busy"},  32'(clear_busy), 1);
    chk({tag, "_count"}, 32'(write_count), 0);
  endtask

  initial begin
    int guard;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Initial clear pass: addresses 0..15, data 0.
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      chk("clr_addr_lit",  32'(ocm_addr), 32'(i));
      chk("clr_write_lit", 32'(ocm_write), 1);
      chk("clr_data_lit",  32'(ocm_writedata), 0);
      chk("clr_busy_lit",  32'(clear_busy), (i == DEPTH - 1) ? 0 : 1);
    end

    // A only: addr 5, data AA.
    step(1, 17'd5, 8'hAA, 0, '0, '0, 0);
    chk("a_only_ready", 32'(reqA_ready), 1);
    step(0, '0, '0, 1, 17'd9, 8'h55, 0);   // B only next
    chk("a_only_addr",  32'(ocm_addr), 5);
    chk("a_only_data",  32'(ocm_writedata), 32'h AA);
    chk("a_only_write", 32'(ocm_write), 1);
    chk("a_only_count", 32'(write_count), 1);

    // Both valid for 4 cycles: A,B,A,B.
    for (int k = 0; k < 4; k++) begin
      step(1, 17'(100 + k), 8'(8'h10 + k), 1, 17'(200 + k), 8'(8'h20 + k), 0);
      chk("rr_grant_a", 32'(reqA_ready), (k % 2 == 0) ? 1 : 0);
      if (k > 0) chk("rr_data", 32'(ocm_writedata), (k % 2 == 1) ? 32'(8'h10 + k - 1) : 32'(8'h20 + k - 1));
    end
    idle();
    chk("rr_last_data", 32'(ocm_writedata), 32'h23);
    chk("rr_count",     32'(write_count), 6);

    // clear_start while B valid.
    step(0, '0, '0, 1, 17'd33, 8'h77, 1);
    chk("cs_b_blocked", 32'(reqB_ready), 0);
    for (int s = 1; s <= 17; s++) begin
      step(0, '0, '0, 1, 17'd33, 8'h77, 0);
      if (s == 1) chk("cs_count_zero", 32'(write_count), 0);
      if (s >= 2) chk("cs_clr_addr", 32'(ocm_addr), 32'(s - 2));
      chk("cs_b_ready", 32'(reqB_ready), (s == 17) ? 1 : 0);
    end
    idle();
    chk("cs_b_addr", 32'(ocm_addr), 33);

    // Reset mid-clear at address 7.
    step(0, '0, '0, 0, '0, '0, 1);
    guard = 0;
    while (!(m_clearing && e_wr && e_addr == 17'd7) && guard < 40) begin
      idle();
      guard++;
    end
    chk("midclr_reached", 32'(ocm_addr), 7);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    #1;
    chk_reset_vals("midrst_hold");
    reset_n = 1'b1;
    idle();
    chk("midrst_restart_addr",  32'(ocm_addr), 0);
    chk("midrst_restart_write", 32'(ocm_write), 1);

    // Randomized phase against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 999) == 0) begin
        reset_n = 1'b0;
        idle();
        reset_n = 1'b1;
      end
      step($urandom_range(0, 3) != 0, AW'($urandom), DW'($urandom),
           $urandom_range(0, 3) != 0, AW'($urandom), DW'($urandom),
           $urandom_range(0, 149) == 0);
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ocm_write_scheduler
`default_nettype wire
